// File: rtl/lock_key_pkg.sv
// Shared definitions for the virtual keypad: key indices, bus width and player states.
// Used by the key player and by the keypad decoder.
package lock_key_pkg;

  localparam int KEY_W    = 12;
  localparam int KEY_STAR = 10;
  localparam int KEY_HASH = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS,
    ST_GAP,
    ST_ENTER_PRESS,
    ST_ENTER_GAP,
    ST_FIN
  } player_state_t;

  function automatic logic nibble_is_bcd(input logic [3:0] nib);
    return (nib <= 4'd9);
  endfunction

endpackage

// File: rtl/key_onehot_enc.sv
// Combinational BCD digit to one-hot key encoder; non-BCD input yields no key and valid=0.
module key_onehot_enc
  import lock_key_pkg::*;
(
  input  logic [3:0]       digit,
  output logic [KEY_W-1:0] key_onehot,
  output logic             valid
);

  always_comb begin
    valid      = nibble_is_bcd(digit);
    key_onehot = '0;
    if (valid) key_onehot = KEY_W'(1) << digit;
  end

endmodule

// File: rtl/keypad_key_player.sv
// Plays a latched 4-digit BCD code as timed one-hot key presses, optionally followed by '#'.
// Every output is a register; abort and reset always leave the keypad fully released.
module keypad_key_player
  import lock_key_pkg::*;
#(
  parameter int HOLD_CYC = 16,
  parameter int GAP_CYC  = 16,
  parameter int CNT_W    = 8
)
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      code,
  input  logic             send_enter,
  input  logic             abort,
  output logic [KEY_W-1:0] Key,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [KEY_W-1:0] HASH_KEY  = KEY_W'(1) << KEY_HASH;

  logic [1:0]       rst_sync_q;
  logic             rst_n_int;

  player_state_t    state_q, state_nxt;
  logic [CNT_W-1:0] timer_q, timer_nxt;
  logic [1:0]       idx_q, idx_nxt;
  logic [11:0]      code_q, code_nxt;
  logic             enter_q, enter_nxt;
  logic [KEY_W-1:0] key_q, key_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic             err_q, err_nxt;

  logic [3:0]       enc_digit;
  logic [3:0]       next_digit;
  logic [KEY_W-1:0] enc_key;
  logic             enc_valid;
  logic             code_ok;

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  // The latched code no longer holds the first digit: only digits 1..3 are replayed from it.
  always_comb begin
    case (idx_q)
      2'd0:    next_digit = code_q[11:8];
      2'd1:    next_digit = code_q[7:4];
      default: next_digit = code_q[3:0];
    endcase
  end

  assign enc_digit = (state_q == ST_IDLE) ? code[15:12] : next_digit;

  key_onehot_enc u_enc (
    .digit      (enc_digit),
    .key_onehot (enc_key),
    .valid      (enc_valid)
  );

  assign code_ok = enc_valid && nibble_is_bcd(code[11:8])
                 && nibble_is_bcd(code[7:4]) && nibble_is_bcd(code[3:0]);

  always_comb begin
    state_nxt = state_q;
    timer_nxt = timer_q + CNT_W'(1);
    idx_nxt   = idx_q;
    code_nxt  = code_q;
    enter_nxt = enter_q;
    key_nxt   = key_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_nxt = '0;
        if (start && !abort) begin
          if (code_ok) begin
            state_nxt = ST_PRESS;
            code_nxt  = code[11:0];
            enter_nxt = send_enter;
            idx_nxt   = 2'd0;
            key_nxt   = enc_key;
            busy_nxt  = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_PRESS: begin
        if (timer_q == HOLD_LAST) begin
          state_nxt = ST_GAP;
          timer_nxt = '0;
          key_nxt   = '0;
        end
      end
      ST_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_nxt = '0;
          if (idx_q != 2'd3) begin
            state_nxt = ST_PRESS;
            idx_nxt   = idx_q + 2'd1;
            key_nxt   = enc_key;
          end else if (enter_q) begin
            state_nxt = ST_ENTER_PRESS;
            key_nxt   = HASH_KEY;
          end else begin
            state_nxt = ST_FIN;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
        end
      end
      ST_ENTER_PRESS: begin
        if (timer_q == HOLD_LAST) begin
          state_nxt = ST_ENTER_GAP;
          timer_nxt = '0;
          key_nxt   = '0;
        end
      end
      ST_ENTER_GAP: begin
        if (timer_q == GAP_LAST) begin
          state_nxt = ST_FIN;
          timer_nxt = '0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
        timer_nxt = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = '0;
        key_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase

    // Abort overrides any transition, including the one that would raise done.
    if (abort && state_q != ST_IDLE) begin
      state_nxt = ST_IDLE;
      timer_nxt = '0;
      idx_nxt   = 2'd0;
      key_nxt   = '0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      code_q  <= '0;
      enter_q <= 1'b0;
      key_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      timer_q <= timer_nxt;
      idx_q   <= idx_nxt;
      code_q  <= code_nxt;
      enter_q <= enter_nxt;
      key_q   <= key_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
    end
  end

  assign Key  = key_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_keypad_key_player.sv
// Directed bench for keypad_key_player with HOLD_CYC = GAP_CYC = 4.
module tb_keypad_key_player;

  localparam int HOLD = 4;
  localparam int GAP  = 4;
  localparam int PH   = HOLD + GAP;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] code = 16'h0000;
  logic        send_enter = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] Key;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  keypad_key_player #(
    .HOLD_CYC (HOLD),
    .GAP_CYC  (GAP),
    .CNT_W    (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .code       (code),
    .send_enter (send_enter),
    .abort      (abort),
    .Key        (Key),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Expected Key in cycle k (k=1 is the cycle right after the accepting edge).
  function automatic logic [11:0] exp_key(input logic [15:0] c, input logic en, input int k);
    int p;
    int w;
    logic [3:0] d;
    logic [11:0] r;
    r = '0;
    if (k >= 1) begin
      p = (k - 1) / PH;
      w = (k - 1) % PH;
      if (w < HOLD) begin
        if (p < 4) begin
          d = c[4*(3-p) +: 4];
          r[d] = 1'b1;
        end else if (p == 4 && en) begin
          r[11] = 1'b1;
        end
      end
    end
    return r;
  endfunction

  // Called away from a clock edge; start is sampled on the next rising edge.
  task automatic do_start(input logic [15:0] c, input logic en);
    code = c;
    send_enter = en;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (Key !== 12'h000) begin errors++; $display("FAIL reset_key: got %h want 000", Key); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    do_start(16'h1234, 1'b0);
    repeat (2) @(negedge clock);
    checks++; if (Key !== 12'h002) begin errors++; $display("FAIL reset_pre_key: got %h want 002", Key); end
    #2 reset = 1'b0;
    #1;
    checks++; if (Key !== 12'h000) begin errors++; $display("FAIL reset_async_key: got %h want 000", Key); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_async_busy: got %b want 0", busy); end
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      checks++;
      if ({Key, busy, done} !== 14'h0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got key=%h busy=%b done=%b want all 0", k, Key, busy, done);
      end
    end
  endtask

  task automatic test_seq_1234();
    do_start(16'h1234, 1'b0);
    for (int k = 1; k <= 36; k++) begin
      @(negedge clock);
      checks++; if (Key !== exp_key(16'h1234, 1'b0, k)) begin errors++; $display("FAIL seq1234_key cyc %0d: got %h want %h", k, Key, exp_key(16'h1234, 1'b0, k)); end
      checks++; if (busy !== 1'(k <= 32)) begin errors++; $display("FAIL seq1234_busy cyc %0d: got %b want %b", k, busy, 1'(k <= 32)); end
      checks++; if (done !== 1'(k == 33)) begin errors++; $display("FAIL seq1234_done cyc %0d: got %b want %b", k, done, 1'(k == 33)); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL seq1234_err cyc %0d: got %b want 0", k, err); end
    end
  endtask

  task automatic test_enter_0909();
    do_start(16'h0909, 1'b1);
    for (int k = 1; k <= 44; k++) begin
      @(negedge clock);
      checks++; if (Key !== exp_key(16'h0909, 1'b1, k)) begin errors++; $display("FAIL enter_key cyc %0d: got %h want %h", k, Key, exp_key(16'h0909, 1'b1, k)); end
      checks++; if (busy !== 1'(k <= 40)) begin errors++; $display("FAIL enter_busy cyc %0d: got %b want %b", k, busy, 1'(k <= 40)); end
      checks++; if (done !== 1'(k == 41)) begin errors++; $display("FAIL enter_done cyc %0d: got %b want %b", k, done, 1'(k == 41)); end
    end
  endtask

  task automatic test_invalid();
    do_start(16'h12A4, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      checks++; if (err !== 1'(k == 1)) begin errors++; $display("FAIL invalid_err cyc %0d: got %b want %b", k, err, 1'(k == 1)); end
      checks++; if ({Key, busy, done} !== 14'h0) begin errors++; $display("FAIL invalid_idle cyc %0d: got key=%h busy=%b done=%b want all 0", k, Key, busy, done); end
    end
  endtask

  task automatic test_abort();
    do_start(16'h1234, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      checks++; if (Key !== exp_key(16'h1234, 1'b0, k)) begin errors++; $display("FAIL abort_pre_key cyc %0d: got %h want %h", k, Key, exp_key(16'h1234, 1'b0, k)); end
    end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    checks++; if ({Key, busy, done} !== 14'h0) begin errors++; $display("FAIL abort_stop: got key=%h busy=%b done=%b want all 0", Key, busy, done); end
    do_start(16'h1234, 1'b0);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clock);
      checks++; if (Key !== exp_key(16'h1234, 1'b0, k)) begin errors++; $display("FAIL abort_restart_key cyc %0d: got %h want %h", k, Key, exp_key(16'h1234, 1'b0, k)); end
      checks++; if (busy !== 1'(k <= 32)) begin errors++; $display("FAIL abort_restart_busy cyc %0d: got %b want %b", k, busy, 1'(k <= 32)); end
      checks++; if (done !== 1'(k == 33)) begin errors++; $display("FAIL abort_restart_done cyc %0d: got %b want %b", k, done, 1'(k == 33)); end
    end
  endtask

  task automatic test_back_to_back();
    do_start(16'h1234, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      checks++; if (Key !== exp_key(16'h1234, 1'b0, k)) begin errors++; $display("FAIL busy_start_key cyc %0d: got %h want %h", k, Key, exp_key(16'h1234, 1'b0, k)); end
      checks++; if (busy !== 1'(k <= 32)) begin errors++; $display("FAIL busy_start_busy cyc %0d: got %b want %b", k, busy, 1'(k <= 32)); end
      checks++; if (done !== 1'(k == 33)) begin errors++; $display("FAIL busy_start_done cyc %0d: got %b want %b", k, done, 1'(k == 33)); end
      if (k == 5) begin
        code = 16'h5678;
        send_enter = 1'b1;
        start = 1'b1;
      end
      if (k == 7) start = 1'b0;
    end
    code = 16'h1234;
    send_enter = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    abort = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      checks++; if ({Key, busy, done, err} !== 15'h0) begin errors++; $display("FAIL abort_start_idle cyc %0d: got key=%h busy=%b done=%b err=%b want all 0", k, Key, busy, done, err); end
    end
  endtask

  initial begin
    test_reset();
    test_seq_1234();
    test_enter_0909();
    test_invalid();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
